// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller:
// FSM states, forwarding source codes and register field positions.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LDSTALL = 2'd1,
    ST_MEMWAIT = 2'd2,
    ST_BAD     = 2'd3
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;

  function automatic logic [4:0] rs_field(
    input logic [31:0] inst,
    input int          lsb
  );
    return inst[lsb +: 5];
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath (master)
// and the hazard controller (slave).
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      id_inst;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [4:0]       ex_rd;
  logic             ex_rfwe;
  logic             ex_is_load;
  logic [4:0]       mem_rd;
  logic             mem_rfwe;
  logic [4:0]       wb_rd;
  logic             wb_rfwe;
  logic             ex_redirect;
  logic             dm_busy;
  logic             pc_en;
  logic             if_id_en;
  logic             id_ex_en;
  logic             ex_mem_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [1:0]       state;

  modport master (
    output id_inst, id_use_rs1, id_use_rs2,
    output ex_rd, ex_rfwe, ex_is_load,
    output mem_rd, mem_rfwe, wb_rd, wb_rfwe,
    output ex_redirect, dm_busy,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en,
    input  if_id_flush, id_ex_flush,
    input  fwd_a, fwd_b,
    input  stall_cnt, flush_cnt, state
  );

  modport slave (
    input  id_inst, id_use_rs1, id_use_rs2,
    input  ex_rd, ex_rfwe, ex_is_load,
    input  mem_rd, mem_rfwe, wb_rd, wb_rfwe,
    input  ex_redirect, dm_busy,
    output pc_en, if_id_en, id_ex_en, ex_mem_en,
    output if_id_flush, id_ex_flush,
    output fwd_a, fwd_b,
    output stall_cnt, flush_cnt, state
  );
endinterface

// File: rtl/hazard_fwd_sel.sv
// Per-operand RAW match detection and forwarding source select.
// A load in EX cannot forward; the controller stalls instead.
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int FWD_EN = 1
) (
  input  logic [4:0] rs_i,
  input  logic       use_i,
  input  logic [4:0] ex_rd_i,
  input  logic       ex_rfwe_i,
  input  logic       ex_is_load_i,
  input  logic [4:0] mem_rd_i,
  input  logic       mem_rfwe_i,
  input  logic [4:0] wb_rd_i,
  input  logic       wb_rfwe_i,
  output logic [1:0] sel_o,
  output logic       m_ex_o,
  output logic       m_mem_o,
  output logic       m_wb_o
);

  assign m_ex_o  = ex_rfwe_i && (ex_rd_i != 5'd0)
                && (ex_rd_i == rs_i) && use_i;
  assign m_mem_o = mem_rfwe_i && (mem_rd_i != 5'd0)
                && (mem_rd_i == rs_i) && use_i;
  assign m_wb_o  = wb_rfwe_i && (wb_rd_i != 5'd0)
                && (wb_rd_i == rs_i) && use_i;

  always_comb begin
    sel_o = FWD_RF;
    if (FWD_EN != 0) begin
      if (m_ex_o && !ex_is_load_i) sel_o = FWD_EX;
      else if (m_mem_o)            sel_o = FWD_MEM;
      else if (m_wb_o)             sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stalls, flushes, forwarding select
// and saturating stall/flush performance counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int FWD_EN = 1
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic [1:0] sel_a, sel_b;
  logic       ma_ex, ma_mem, ma_wb;
  logic       mb_ex, mb_mem, mb_wb;
  logic       lu;

  logic pc_en, if_id_en, id_ex_en, ex_mem_en;
  logic if_id_flush, id_ex_flush;

  hazard_fwd_sel #(.FWD_EN(FWD_EN)) u_fwd_a (
    .rs_i        (rs_field(bus.id_inst, RS1_LSB)),
    .use_i       (bus.id_use_rs1),
    .ex_rd_i     (bus.ex_rd),
    .ex_rfwe_i   (bus.ex_rfwe),
    .ex_is_load_i(bus.ex_is_load),
    .mem_rd_i    (bus.mem_rd),
    .mem_rfwe_i  (bus.mem_rfwe),
    .wb_rd_i     (bus.wb_rd),
    .wb_rfwe_i   (bus.wb_rfwe),
    .sel_o       (sel_a),
    .m_ex_o      (ma_ex),
    .m_mem_o     (ma_mem),
    .m_wb_o      (ma_wb)
  );

  hazard_fwd_sel #(.FWD_EN(FWD_EN)) u_fwd_b (
    .rs_i        (rs_field(bus.id_inst, RS2_LSB)),
    .use_i       (bus.id_use_rs2),
    .ex_rd_i     (bus.ex_rd),
    .ex_rfwe_i   (bus.ex_rfwe),
    .ex_is_load_i(bus.ex_is_load),
    .mem_rd_i    (bus.mem_rd),
    .mem_rfwe_i  (bus.mem_rfwe),
    .wb_rd_i     (bus.wb_rd),
    .wb_rfwe_i   (bus.wb_rfwe),
    .sel_o       (sel_b),
    .m_ex_o      (mb_ex),
    .m_mem_o     (mb_mem),
    .m_wb_o      (mb_wb)
  );

  // Without forwarding every in-flight producer must drain first
  always_comb begin
    lu = bus.ex_is_load && (ma_ex || mb_ex);
    if (FWD_EN == 0)
      lu = ma_ex || ma_mem || ma_wb || mb_ex || mb_mem || mb_wb;
  end

  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    ex_mem_en   = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    state_d     = ST_RUN;
    if (rst) begin
      state_d = ST_RUN;
    end else if (bus.dm_busy) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      state_d   = ST_MEMWAIT;
    end else if (bus.ex_redirect) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (lu) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
      state_d     = ST_LDSTALL;
    end
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!pc_en && stall_q != '1)
      stall_d = stall_q + 1'b1;
    if (if_id_flush && flush_q != '1)
      flush_d = flush_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign bus.pc_en       = pc_en;
  assign bus.if_id_en    = if_id_en;
  assign bus.id_ex_en    = id_ex_en;
  assign bus.ex_mem_en   = ex_mem_en;
  assign bus.if_id_flush = if_id_flush;
  assign bus.id_ex_flush = id_ex_flush;
  assign bus.fwd_a       = rst ? FWD_RF : sel_a;
  assign bus.fwd_b       = rst ? FWD_RF : sel_b;
  assign bus.stall_cnt   = stall_q;
  assign bus.flush_cnt   = flush_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl, with a second
// forwarding-disabled instance driven by the same inputs.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(4)) a ();
  hazard_ctrl_if #(.CNT_W(4)) b ();

  hazard_ctrl #(.CNT_W(4), .FWD_EN(1)) dut (
    .clk(clk), .rst(rst), .bus(a)
  );
  hazard_ctrl #(.CNT_W(4), .FWD_EN(0)) dut_nf (
    .clk(clk), .rst(rst), .bus(b)
  );

  assign b.id_inst     = a.id_inst;
  assign b.id_use_rs1  = a.id_use_rs1;
  assign b.id_use_rs2  = a.id_use_rs2;
  assign b.ex_rd       = a.ex_rd;
  assign b.ex_rfwe     = a.ex_rfwe;
  assign b.ex_is_load  = a.ex_is_load;
  assign b.mem_rd      = a.mem_rd;
  assign b.mem_rfwe    = a.mem_rfwe;
  assign b.wb_rd       = a.wb_rd;
  assign b.wb_rfwe     = a.wb_rfwe;
  assign b.ex_redirect = a.ex_redirect;
  assign b.dm_busy     = a.dm_busy;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] r1,
                                     input logic [4:0] r2);
    return {7'b0, r2, r1, 3'b0, 5'b0, 7'b0110011};
  endfunction

  task automatic clr();
    a.id_inst     = 32'h0;
    a.id_use_rs1  = 1'b0;
    a.id_use_rs2  = 1'b0;
    a.ex_rd       = 5'd0;
    a.ex_rfwe     = 1'b0;
    a.ex_is_load  = 1'b0;
    a.mem_rd      = 5'd0;
    a.mem_rfwe    = 1'b0;
    a.wb_rd       = 5'd0;
    a.wb_rfwe     = 1'b0;
    a.ex_redirect = 1'b0;
    a.dm_busy     = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] ctl_a();
    return {a.pc_en, a.if_id_en, a.id_ex_en,
            a.ex_mem_en, a.if_id_flush, a.id_ex_flush};
  endfunction

  task automatic set_lu(input logic [4:0] r);
    a.ex_rd      = r;
    a.ex_rfwe    = 1'b1;
    a.ex_is_load = 1'b1;
    a.id_inst    = mk(r, 5'd0);
    a.id_use_rs1 = 1'b1;
  endtask

  initial begin
    // reset overrides busy/redirect and a pending load-use
    clr();
    rst = 1'b1;
    a.dm_busy     = 1'b1;
    a.ex_redirect = 1'b1;
    set_lu(5'd5);
    a.mem_rd   = 5'd5;
    a.mem_rfwe = 1'b1;
    @(negedge clk);
    chk("rst_ctl", ctl_a(), 6'b111100);
    chk("rst_fwd_a", a.fwd_a, 2'b00);
    chk("rst_nf_ctl", {b.pc_en, b.id_ex_flush}, 2'b10);
    tick();
    chk("rst_state", a.state, 0);
    chk("rst_stall", a.stall_cnt, 0);
    chk("rst_flush", a.flush_cnt, 0);
    rst = 1'b0;
    clr();

    // load-use on rs1 = x5
    set_lu(5'd5);
    @(negedge clk);
    chk("lu_ctl", ctl_a(), 6'b001101);
    chk("lu_fwd_a", a.fwd_a, 2'b00);
    chk("lu_stall0", a.stall_cnt, 0);
    tick();
    chk("lu_stall1", a.stall_cnt, 1);
    chk("lu_state", a.state, 1);
    clr();
    a.id_inst    = mk(5'd5, 5'd0);
    a.id_use_rs1 = 1'b1;
    a.mem_rd     = 5'd5;
    a.mem_rfwe   = 1'b1;
    @(negedge clk);
    chk("lu_post_fwd_a", a.fwd_a, 2'b10);
    chk("lu_post_ctl", ctl_a(), 6'b111100);
    tick();
    chk("lu_post_state", a.state, 0);

    // EX and MEM both write x7, rs2 = x7
    clr();
    a.ex_rd      = 5'd7;
    a.ex_rfwe    = 1'b1;
    a.mem_rd     = 5'd7;
    a.mem_rfwe   = 1'b1;
    a.id_inst    = mk(5'd0, 5'd7);
    a.id_use_rs2 = 1'b1;
    @(negedge clk);
    chk("ex_fwd_b", a.fwd_b, 2'b01);
    chk("ex_fwd_a", a.fwd_a, 2'b00);
    chk("ex_pc_en", a.pc_en, 1);
    chk("nf_fwd_b", b.fwd_b, 2'b00);
    chk("nf_pc_en", b.pc_en, 0);
    a.wb_rd      = 5'd3;
    a.wb_rfwe    = 1'b1;
    a.id_inst    = mk(5'd3, 5'd7);
    a.id_use_rs1 = 1'b1;
    @(negedge clk);
    chk("wb_fwd_a", a.fwd_a, 2'b11);
    chk("wb_fwd_b", a.fwd_b, 2'b01);
    a.mem_rd = 5'd3;
    @(negedge clk);
    chk("mem_over_wb", a.fwd_a, 2'b10);
    chk("ex_only_b", a.fwd_b, 2'b01);
    tick();

    // redirect together with load-use
    clr();
    set_lu(5'd5);
    a.ex_redirect = 1'b1;
    @(negedge clk);
    chk("redir_ctl", ctl_a(), 6'b111111);
    tick();
    chk("redir_stall", a.stall_cnt, 1);
    chk("redir_flush", a.flush_cnt, 1);
    chk("redir_state", a.state, 0);

    // x0 destination and unused source never stall
    clr();
    a.ex_rfwe    = 1'b1;
    a.ex_is_load = 1'b1;
    a.id_use_rs1 = 1'b1;
    a.id_use_rs2 = 1'b1;
    @(negedge clk);
    chk("x0_ctl", ctl_a(), 6'b111100);
    chk("x0_fwd", {a.fwd_a, a.fwd_b}, 4'b0000);
    a.ex_rd      = 5'd9;
    a.id_inst    = mk(5'd9, 5'd9);
    a.id_use_rs1 = 1'b0;
    a.id_use_rs2 = 1'b0;
    @(negedge clk);
    chk("nouse_pc_en", a.pc_en, 1);
    tick();

    // memory busy for three cycles with redirect held
    clr();
    a.dm_busy     = 1'b1;
    a.ex_redirect = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("busy_ctl", ctl_a(), 6'b000000);
      tick();
      chk("busy_state", a.state, 2);
    end
    a.dm_busy = 1'b0;
    @(negedge clk);
    chk("resume_ctl", ctl_a(), 6'b111111);
    chk("resume_state", a.state, 2);
    tick();
    chk("resume_state_run", a.state, 0);
    chk("resume_flush", a.flush_cnt, 2);
    chk("resume_stall", a.stall_cnt, 4);

    // back-to-back load-use saturates stall_cnt
    clr();
    set_lu(5'd6);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 1) chk("b2b_ctl", ctl_a(), 6'b001101);
      tick();
    end
    chk("sat_stall", a.stall_cnt, 15);
    chk("sat_state", a.state, 1);
    clr();
    @(negedge clk);
    chk("sat_release", a.pc_en, 1);
    tick();
    chk("sat_hold", a.stall_cnt, 15);
    chk("sat_state_run", a.state, 0);

    // reset in the middle of MEMWAIT
    a.dm_busy = 1'b1;
    tick();
    tick();
    chk("mw_state", a.state, 2);
    rst = 1'b1;
    @(negedge clk);
    chk("mw_rst_ctl", ctl_a(), 6'b111100);
    tick();
    chk("mw_rst_state", a.state, 0);
    chk("mw_rst_stall", a.stall_cnt, 0);
    chk("mw_rst_flush", a.flush_cnt, 0);
    rst = 1'b0;
    clr();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
